mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_pick.sv | 25 ++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the mem_arbiter slice.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the fetch and data ports.
// ptr=0 favours the data port, ptr=1 favours the fetch port on a collision.
module arb_pick (
  input  logic req_i,
  input  logic req_d,
  input  logic ptr,
  output logic grant_i,
  output logic grant_d
);

  // Pick at most one winner from the qualified requests.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_d && (!req_i || !ptr)) begin
      grant_d = 1'b1;
    end else if (req_i) begin
      grant_i = 1'b1;
    end else begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single shared memory port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate the winner of
// simultaneous requests; otherwise the data port always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t state_r;
  state_t state_s;
  logic   qual_i_s;
  logic   qual_d_s;
  logic   grant_i_s;
  logic   grant_d_s;
  logic   ptr_s;

  // A port whose ack is pulsing this cycle has already been served.
  assign qual_i_s = i_req & ~i_ack;
  assign qual_d_s = d_req & ~d_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 when the last contested grant went to the data port. Uncontested
  // grants leave it alone so that successive collisions alternate.
  logic last_d_r;

  // Track the winner of each collision seen in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d_r <= 1'b0;
    end else if ((state_r == IDLE) && qual_i_s && qual_d_s) begin
      last_d_r <= grant_d_s;
    end else begin
      last_d_r <= last_d_r;
    end
  end

  assign ptr_s = last_d_r;
`else
  assign ptr_s = 1'b0;
`endif

  arb_pick u_pick (
    .req_i   (qual_i_s),
    .req_d   (qual_d_s),
    .ptr     (ptr_s),
    .grant_i (grant_i_s),
    .grant_d (grant_d_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode: issue from IDLE, wait for mem_ack while busy.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_s = BUSY_D;
        end else if (grant_i_s) begin
          state_s = BUSY_I;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY_I;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY_D;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered memory request, completion pulses and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= {DATA_W{1'b0}};
      d_rdata   <= {DATA_W{1'b0}};
      busy      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      busy  <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i_s) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= {DATA_W{1'b0}};
          end else begin
            mem_req <= 1'b0;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            i_rdata <= mem_rdata;
            i_ack   <= 1'b1;
          end else begin
            mem_req <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            d_ack   <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end else begin
              d_rdata <= d_rdata;
            end
          end else begin
            mem_req <= 1'b1;
          end
        end
        default: begin
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Simultaneous load pair: data 0x500, fetch 0x600; first_d says who wins.
  task automatic do_pair(input string tag, input logic first_d);
    i_req = 1'b1; i_addr = 32'h0000_0600;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
    tick();
    chk32({tag, "_first_addr"}, mem_addr, first_d ? 32'h0000_0500 : 32'h0000_0600);
    mem_ack = 1'b1; mem_rdata = 32'h1111_0000;
    tick();
    chk1({tag, "_first_d_ack"}, d_ack, first_d);
    chk1({tag, "_first_i_ack"}, i_ack, !first_d);
    if (first_d) d_req = 1'b0; else i_req = 1'b0;
    mem_ack = 1'b0;
    tick();
    chk32({tag, "_second_addr"}, mem_addr, first_d ? 32'h0000_0600 : 32'h0000_0500);
    mem_ack = 1'b1; mem_rdata = 32'h2222_0000;
    tick();
    chk1({tag, "_second_d_ack"}, d_ack, !first_d);
    chk1({tag, "_second_i_ack"}, i_ack, first_d);
    i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_i_ack", i_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_i_rdata", i_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
    tick();

    // Fetch-only read with zero-wait memory.
    i_req = 1'b1; i_addr = 32'h0000_0040;
    tick();
    chk1("fetch_mem_req", mem_req, 1'b1);
    chk1("fetch_mem_we", mem_we, 1'b0);
    chk32("fetch_mem_addr", mem_addr, 32'h0000_0040);
    chk32("fetch_mem_wdata", mem_wdata, 32'h0);
    chk1("fetch_busy", busy, 1'b1);
    chk1("fetch_no_early_ack", i_ack, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h0051_3023;
    tick();
    chk1("fetch_i_ack", i_ack, 1'b1);
    chk32("fetch_i_rdata", i_rdata, 32'h0051_3023);
    chk1("fetch_d_ack", d_ack, 1'b0);
    chk1("fetch_mem_req_clr", mem_req, 1'b0);
    chk1("fetch_busy_clr", busy, 1'b0);
    i_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk1("fetch_ack_one_cycle", i_ack, 1'b0);
    chk32("fetch_rdata_held", i_rdata, 32'h0051_3023);

    // Stray ack while idle.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    chk1("stray_i_ack", i_ack, 1'b0);
    chk1("stray_d_ack", d_ack, 1'b0);
    chk32("stray_i_rdata", i_rdata, 32'h0051_3023);
    chk32("stray_d_rdata", d_rdata, 32'h0);
    chk1("stray_busy", busy, 1'b0);
    mem_ack = 1'b0;
    tick();

    // Collision: store wins, fetch issues in the d_ack cycle.
    i_req = 1'b1; i_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    tick();
    chk1("coll_mem_we", mem_we, 1'b1);
    chk32("coll_mem_addr", mem_addr, 32'h0000_0100);
    chk32("coll_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk1("coll_d_ack", d_ack, 1'b1);
    chk32("coll_store_no_rdata", d_rdata, 32'h0);
    d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    tick();
    chk1("coll_fetch_req", mem_req, 1'b1);
    chk32("coll_fetch_addr", mem_addr, 32'h0000_0080);
    chk1("coll_fetch_we", mem_we, 1'b0);
    chk32("coll_fetch_wdata", mem_wdata, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    chk1("coll_i_ack", i_ack, 1'b1);
    chk32("coll_i_rdata", i_rdata, 32'hCAFE_F00D);
    i_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Slow memory: load held for 5 cycles, fetch arrives meanwhile.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        i_req = 1'b1; i_addr = 32'h0000_0300;
      end
      tick();
      chk1("slow_mem_req", mem_req, 1'b1);
      chk32("slow_mem_addr", mem_addr, 32'h0000_0200);
      chk1("slow_mem_we", mem_we, 1'b0);
      chk1("slow_busy", busy, 1'b1);
      chk1("slow_no_d_ack", d_ack, 1'b0);
      chk1("slow_no_i_ack", i_ack, 1'b0);
    end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    tick();
    chk1("slow_d_ack", d_ack, 1'b1);
    chk32("slow_d_rdata", d_rdata, 32'hA5A5_5A5A);
    d_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk1("slow_d_ack_once", d_ack, 1'b0);
    chk32("slow_waiting_fetch_addr", mem_addr, 32'h0000_0300);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    tick();
    chk1("slow_i_ack", i_ack, 1'b1);
    chk32("slow_i_rdata", i_rdata, 32'h0BAD_CAFE);
    i_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Reset during BUSY_D aborts the load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    tick();
    chk1("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk1("abort_busy_async", busy, 1'b0);
    chk1("abort_mem_req_async", mem_req, 1'b0);
    chk32("abort_d_rdata_async", d_rdata, 32'h0);
    d_req = 1'b0;
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    chk1("abort_no_d_ack", d_ack, 1'b0);
    chk1("abort_no_i_ack", i_ack, 1'b0);
    chk1("abort_idle", busy, 1'b0);
    chk32("abort_d_rdata", d_rdata, 32'h0);
    mem_ack = 1'b0;
    tick();

    // Repeated collisions after reset.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    do_pair("rr_pair1", 1'b1);
    do_pair("rr_pair2", 1'b0);
    do_pair("rr_pair3", 1'b1);
`else
    do_pair("fix_pair1", 1'b1);
    do_pair("fix_pair2", 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
